// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Two-requester register-file write arbiter (round-robin or
//                fixed priority) with a registered write port and a busy
//                scoreboard for read-port hazard queries.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int RR_ENABLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [4:0]  req0_reg,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    input  logic [4:0]  req1_reg,
    input  logic [31:0] req1_data,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_reg,
    input  logic [4:0]  chk_reg1,
    input  logic [4:0]  chk_reg2,
    output logic        chk_busy1,
    output logic        chk_busy2,
    output logic [5:0]  pending_count
);

    localparam logic [31:0] c_x0_mask = 32'd1;

    logic        r_last_grant;
    logic        r_we;
    logic [4:0]  r_wreg;
    logic [31:0] r_wdata;
    logic [31:0] r_busy;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_xfer;
    logic [4:0]  w_xfer_reg;
    logic [31:0] w_xfer_data;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [5:0]  w_pending;

    // Grants are gated by reset so both readies drop the moment reset asserts.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (reset) begin
            if (req0_valid && req1_valid) begin
                if (RR_ENABLE != 0) begin
                    w_grant0 = r_last_grant;
                    w_grant1 = ~r_last_grant;
                end else begin
                    w_grant0 = 1'b1;
                end
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign w_xfer      = w_grant0 | w_grant1;
    assign w_xfer_reg  = w_grant1 ? req1_reg  : req0_reg;
    assign w_xfer_data = w_grant1 ? req1_data : req0_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_wreg       <= 5'd0;
            r_wdata      <= 32'd0;
        end else begin
            if (w_xfer) begin
                r_last_grant <= w_grant1;
            end
            // x0 writes complete the handshake but never reach the port.
            r_we <= w_xfer && (w_xfer_reg != 5'd0);
            if (w_xfer && (w_xfer_reg != 5'd0)) begin
                r_wreg  <= w_xfer_reg;
                r_wdata <= w_xfer_data;
            end
        end
    end

    // Set is applied after clear so a same-edge reservation keeps the bit busy.
    assign w_clr_mask = w_xfer    ? (32'd1 << w_xfer_reg) : 32'd0;
    assign w_set_mask = rsv_valid ? (32'd1 << rsv_reg)    : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~c_x0_mask;
        end
    end

    always_comb begin
        w_pending = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_pending = w_pending + {5'd0, r_busy[i]};
        end
    end

    assign req0_ready      = w_grant0;
    assign req1_ready      = w_grant1;
    assign rf_write_enable = r_we;
    assign rf_write_reg    = r_wreg;
    assign rf_write_data   = r_wdata;
    assign chk_busy1       = r_busy[chk_reg1];
    assign chk_busy2       = r_busy[chk_reg2];
    assign pending_count   = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Self-checking bench for regfile_write_arbiter: directed
//                scenarios plus random traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_reg, req1_reg;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        rsv_valid;
    logic [4:0]  rsv_reg, chk_reg1, chk_reg2;
    logic        chk_busy1, chk_busy2;
    logic [5:0]  pending_count;

    logic        fp_req0_valid, fp_req1_valid;
    logic [4:0]  fp_req0_reg, fp_req1_reg;
    logic [31:0] fp_req0_data, fp_req1_data;
    logic        fp_req0_ready, fp_req1_ready;
    logic        fp_we;
    logic [4:0]  fp_wreg;
    logic [31:0] fp_wdata;
    logic        fp_busy1, fp_busy2;
    logic [5:0]  fp_pending;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int          m_last;
    int          m_g;
    logic        m_we;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic [31:0] m_busy;

    regfile_write_arbiter #(.RR_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .pending_count(pending_count)
    );

    regfile_write_arbiter #(.RR_ENABLE(0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(fp_req0_valid), .req0_reg(fp_req0_reg), .req0_data(fp_req0_data),
        .req1_valid(fp_req1_valid), .req1_reg(fp_req1_reg), .req1_data(fp_req1_data),
        .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
        .rf_write_enable(fp_we), .rf_write_reg(fp_wreg), .rf_write_data(fp_wdata),
        .rsv_valid(1'b0), .rsv_reg(5'd0), .chk_reg1(5'd0), .chk_reg2(5'd0),
        .chk_busy1(fp_busy1), .chk_busy2(fp_busy2), .pending_count(fp_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_last  = 1;
        m_g     = -1;
        m_we    = 1'b0;
        m_wreg  = 5'd0;
        m_wdata = 32'd0;
        m_busy  = 32'd0;
    endtask

    // Check one cycle against the model, cross the rising edge, land on the next falling edge.
    task automatic cycle();
        int          g;
        logic [4:0]  r;
        logic [31:0] d;
        #1;
        g = -1;
        if (reset) begin
            if (req0_valid && req1_valid) g = 1 - m_last;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        chk("rf_we",      32'(rf_write_enable), 32'(m_we));
        chk("rf_reg",     32'(rf_write_reg), 32'(m_wreg));
        chk("rf_data",    rf_write_data, m_wdata);
        chk("chk_busy1",  32'(chk_busy1), 32'(m_busy[chk_reg1]));
        chk("chk_busy2",  32'(chk_busy2), 32'(m_busy[chk_reg2]));
        chk("pending",    32'(pending_count), 32'($countones(m_busy)));
        @(posedge clk);
        if (reset) begin
            m_we = 1'b0;
            if (g >= 0) begin
                r = (g == 1) ? req1_reg  : req0_reg;
                d = (g == 1) ? req1_data : req0_data;
                m_last    = g;
                m_busy[r] = 1'b0;
                if (r != 5'd0) begin
                    m_we    = 1'b1;
                    m_wreg  = r;
                    m_wdata = d;
                end
            end
            if (rsv_valid && rsv_reg != 5'd0) m_busy[rsv_reg] = 1'b1;
        end
        m_g = g;
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] rr_regs [4];
        rr_regs = '{5'd1, 5'd2, 5'd1, 5'd2};

        reset = 1'b0;
        req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h1;
        req1_valid = 1'b0; req1_reg = 5'd0; req1_data = 32'h0;
        rsv_valid = 1'b0; rsv_reg = 5'd0; chk_reg1 = 5'd0; chk_reg2 = 5'd0;
        fp_req0_valid = 1'b0; fp_req0_reg = 5'd0; fp_req0_data = 32'd0;
        fp_req1_valid = 1'b0; fp_req1_reg = 5'd0; fp_req1_data = 32'd0;
        model_reset();

        // Reset state, with a valid held during reset
        #3;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_we", 32'(rf_write_enable), 32'd0);
        chk("rst_pending", 32'(pending_count), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b1;

        // Single request, latency 1
        req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
        cycle();
        req0_valid = 1'b0;
        #1;
        chk("single_we", 32'(rf_write_enable), 32'd1);
        chk("single_data", rf_write_data, 32'hDEADBEEF);
        cycle();
        chk("single_we_off", 32'(rf_write_enable), 32'd0);
        cycle();

        // Round-robin: first set last_grant to 1 via a lone req1
        req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 32'h22;
        cycle();
        req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'h11;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_seq", 32'(rf_write_reg), 32'(rr_regs[k]));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();

        // Fixed priority instance: req0 always wins
        fp_req0_valid = 1'b1; fp_req0_reg = 5'd9;  fp_req0_data = 32'h99;
        fp_req1_valid = 1'b1; fp_req1_reg = 5'd10; fp_req1_data = 32'hAA;
        #1;
        chk("fp_ready1", 32'(fp_req1_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("fp_ready0", 32'(fp_req0_ready), 32'd1);
            chk("fp_ready1", 32'(fp_req1_ready), 32'd0);
            chk("fp_we", 32'(fp_we), 32'd1);
            chk("fp_reg", 32'(fp_wreg), 32'd9);
        end
        fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;

        // Scoreboard: reserve 7, write 7, same-edge reserve+write
        rsv_valid = 1'b1; rsv_reg = 5'd7; chk_reg1 = 5'd7; chk_reg2 = 5'd2;
        cycle();
        rsv_valid = 1'b0;
        #1;
        chk("sb_busy", 32'(chk_busy1), 32'd1);
        chk("sb_pending", 32'(pending_count), 32'd1);
        req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'h77;
        cycle();
        req1_valid = 1'b0;
        #1;
        chk("sb_clr", 32'(chk_busy1), 32'd0);
        chk("sb_clr_cnt", 32'(pending_count), 32'd0);
        rsv_valid = 1'b1;
        cycle();
        req1_valid = 1'b1;
        cycle();
        rsv_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("sb_set_wins", 32'(chk_busy1), 32'd1);

        // x0: granted but never written, never reserved
        req0_valid = 1'b1; req0_reg = 5'd0; req0_data = 32'h5555;
        cycle();
        req0_valid = 1'b0;
        #1;
        chk("x0_we", 32'(rf_write_enable), 32'd0);
        rsv_valid = 1'b1; rsv_reg = 5'd0; chk_reg2 = 5'd0;
        cycle();
        rsv_valid = 1'b0;
        #1;
        chk("x0_pending", 32'(pending_count), 32'd1);

        // Reset while a write sits in the output register
        req0_valid = 1'b1; req0_reg = 5'd12; req0_data = 32'hCAFEF00D;
        cycle();
        req0_valid = 1'b0;
        #1;
        chk("mid_we_before", 32'(rf_write_enable), 32'd1);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_we", 32'(rf_write_enable), 32'd0);
        chk("mid_reg", 32'(rf_write_reg), 32'd0);
        chk("mid_data", rf_write_data, 32'd0);
        chk("mid_pending", 32'(pending_count), 32'd0);
        req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 32'h44;
        cycle();
        reset = 1'b1;
        #1;
        chk("post_rst_grant0", 32'(req0_ready), 32'd1);
        cycle();

        // Random traffic honouring the hold-until-transfer rule
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || m_g == 0) begin
                req0_valid = ($urandom_range(0, 1) == 1);
                req0_reg   = 5'($urandom_range(0, 7));
                req0_data  = $urandom;
            end
            if (!req1_valid || m_g == 1) begin
                req1_valid = ($urandom_range(0, 1) == 1);
                req1_reg   = 5'($urandom_range(0, 7));
                req1_data  = $urandom;
            end
            rsv_valid = ($urandom_range(0, 9) < 4);
            rsv_reg   = 5'($urandom_range(0, 7));
            chk_reg1  = 5'($urandom_range(0, 7));
            chk_reg2  = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter RR_ENABLE, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with requester 0 winning.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset=0 resets the block).
REQ-004 The block SHALL have ports req0_valid (input, 1), req0_reg (input, 5) and req0_data (input, 32): write request from requester 0 (ALU writeback).
REQ-005 The block SHALL have ports req1_valid (input, 1), req1_reg (input, 5) and req1_data (input, 32): write request from requester 1 (load writeback).
REQ-006 The block SHALL have ports req0_ready and req1_ready, each output, 1 bit: grant for the current cycle.
REQ-007 The block SHALL have ports rf_write_enable (output, 1), rf_write_reg (output, 5) and rf_write_data (output, 32): registered drive of the register-file write port.
REQ-008 The block SHALL have ports rsv_valid (input, 1) and rsv_reg (input, 5): reservation of a destination register at issue.
REQ-009 The block SHALL have ports chk_reg1 and chk_reg2 (input, 5 each) and chk_busy1 and chk_busy2 (output, 1 each): hazard query for the two read ports.
REQ-010 The block SHALL have port pending_count, output, 6 bits: number of reserved registers.

Function
REQ-011 Handshake: a transfer SHALL occur when reqN_valid and reqN_ready are both 1; the requester holds valid, reg and data stable until the transfer.
REQ-012 reqN_ready SHALL be combinational from the valids and the arbitration state; at most one ready is high per cycle, and ready is never high while valid is low.
REQ-013 When exactly one requester is valid, it SHALL be granted in the same cycle.
REQ-014 When both are valid and RR_ENABLE=1, the requester other than last_grant SHALL win; last_grant updates to the granted index on every transfer.
REQ-015 When both are valid and RR_ENABLE=0, requester 0 SHALL always win.
REQ-016 A transfer at edge N SHALL present rf_write_enable=1 with the granted reg and data during cycle N+1 (latency 1); with no transfer, rf_write_enable=0 in the next cycle.
REQ-017 rf_write_reg and rf_write_data SHALL hold their last values while rf_write_enable=0.
REQ-018 A request with reg=0 SHALL be granted and update last_grant, but SHALL produce rf_write_enable=0.
REQ-019 Scoreboard: busy[31:0]; rsv_valid=1 with rsv_reg!=0 SHALL set busy[rsv_reg] at the edge.
REQ-020 A transfer to register r SHALL clear busy[r] at the transfer edge.
REQ-021 If a set and a clear target the same register at the same edge, set SHALL win (busy stays 1).
REQ-022 busy[0] SHALL be constantly 0.
REQ-023 chk_busyN SHALL equal busy[chk_regN] combinationally.
REQ-024 pending_count SHALL equal the population count of busy (range 0-31).

Reset
REQ-025 With reset=0, the block SHALL immediately force rf_write_enable=0, rf_write_reg=0, rf_write_data=0, busy=0, pending_count=0, both readies=0 and last_grant=1, independent of clk.
REQ-026 An in-flight write in the output register SHALL be dropped on reset, and requests held across reset SHALL be arbitrated normally from the first edge after release.

Verification
REQ-027 Single request: req0 valid, reg 5, data 0xDEADBEEF in cycle N -> req0_ready=1 in N; rf_write_enable=1, reg 5, data 0xDEADBEEF in N+1; rf_write_enable=0 in N+2.
REQ-028 Round-robin: RR_ENABLE=1, both valid continuously, req0 reg 1, req1 reg 2 -> grants 0,1,0,1 and rf_write_reg sequence 1,2,1,2.
REQ-029 Fixed priority: RR_ENABLE=0, both valid for 4 cycles -> req1_ready=0 throughout and four writes to req0_reg.
REQ-030 Scoreboard: reserve reg 7 -> chk_busy1=1 (chk_reg1=7) and pending_count=1 next cycle; req1 write to 7 -> both 0 after the edge; reserve 7 at the same edge as a write to 7 -> busy stays 1.
REQ-031 x0: request to reg 0 -> ready=1 and rf_write_enable stays 0; reserve reg 0 -> pending_count stays 0.
REQ-032 Reset mid-write: drop reset while rf_write_enable=1 -> outputs 0 at once; after release, first conflict goes to req0.
